rtc_bcd_scanner: RTL and testbench

//  Upstream feeder of the VGA clock display. Cycles through the 9 RTC fields (date, month, year,

---
 rtl/rtc_bcd_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_rtc_bcd_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_scanner.sv
// rtc_bcd_scanner: polls the nine RTC date/time/timer fields over a req/ack read port and
// presents each byte as BCD tens/units tagged with its slot, plus a free-running cursor blink.
module rtc_bcd_scanner #(
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 4,
    parameter int REFRESH_CYC = 1_000_000,
    parameter int BLINK_CYC   = 25_000_000
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       pausa,
    input  logic       rd_ack,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    output logic [3:0] decenas,
    output logic [3:0] unidades,
    output logic [3:0] direccion,
    output logic       dato_valido,
    output logic       rd_error,
    output logic       cursor
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_CYC - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_REFRESH = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [3:0]    slot_q, slot_d;
    logic [TW-1:0] waitCnt_q, waitCnt_d;
    logic [GW-1:0] gapCnt_q, gapCnt_d;
    logic [RW-1:0] refCnt_q, refCnt_d;
    logic [7:0]    data_q, data_d;
    logic          pauseHold_q, pauseHold_d;
    logic [3:0]    dec_q, dec_d;
    logic [3:0]    uni_q, uni_d;
    logic [3:0]    dir_q, dir_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [BW-1:0] blinkCnt_q;
    logic          cursor_q;
    logic          tensBad, unitsBad;

    assign tensBad  = (data_q[7:4] > 4'd9);
    assign unitsBad = (data_q[3:0] > 4'd9);

    // A pause seen anywhere during a read is remembered so the read still finishes first.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        waitCnt_d   = waitCnt_q;
        gapCnt_d    = gapCnt_q;
        refCnt_d    = refCnt_q;
        data_d      = data_q;
        pauseHold_d = pauseHold_q;
        dec_d       = dec_q;
        uni_d       = uni_q;
        dir_d       = dir_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                slot_d      = 4'd0;
                pauseHold_d = 1'b0;
                if (!pausa) state_d = S_REQ;
            end
            S_REQ: begin
                waitCnt_d = '0;
                state_d   = S_WAIT;
                if (pausa) pauseHold_d = 1'b1;
            end
            S_WAIT: begin
                if (pausa) pauseHold_d = 1'b1;
                if (rd_ack) begin
                    data_d  = rd_data;
                    state_d = S_LOAD;
                end else if (waitCnt_q == T_LAST) begin
                    err_d       = 1'b1;
                    gapCnt_d    = '0;
                    pauseHold_d = 1'b0;
                    state_d     = (pausa || pauseHold_q) ? S_IDLE : S_GAP;
                end else begin
                    waitCnt_d = waitCnt_q + TW'(1);
                end
            end
            S_LOAD: begin
                dec_d       = tensBad  ? 4'd0 : data_q[7:4];
                uni_d       = unitsBad ? 4'd0 : data_q[3:0];
                dir_d       = slot_q;
                valid_d     = 1'b1;
                err_d       = err_q | tensBad | unitsBad;
                gapCnt_d    = '0;
                pauseHold_d = 1'b0;
                state_d     = (pausa || pauseHold_q) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (pausa) begin
                    state_d = S_IDLE;
                end else if (gapCnt_q == G_LAST) begin
                    if (slot_q == 4'd8) begin
                        refCnt_d = '0;
                        state_d  = S_REFRESH;
                    end else begin
                        slot_d  = slot_q + 4'd1;
                        state_d = S_REQ;
                    end
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end
            S_REFRESH: begin
                if (pausa) begin
                    state_d = S_IDLE;
                end else if (refCnt_q == R_LAST) begin
                    slot_d  = 4'd0;
                    state_d = S_REQ;
                end else begin
                    refCnt_d = refCnt_q + RW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            slot_q      <= 4'd0;
            waitCnt_q   <= '0;
            gapCnt_q    <= '0;
            refCnt_q    <= '0;
            data_q      <= 8'd0;
            pauseHold_q <= 1'b0;
            dec_q       <= 4'd0;
            uni_q       <= 4'd0;
            dir_q       <= 4'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            waitCnt_q   <= waitCnt_d;
            gapCnt_q    <= gapCnt_d;
            refCnt_q    <= refCnt_d;
            data_q      <= data_d;
            pauseHold_q <= pauseHold_d;
            dec_q       <= dec_d;
            uni_q       <= uni_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            blinkCnt_q <= '0;
            cursor_q   <= 1'b0;
        end else if (blinkCnt_q == B_LAST) begin
            blinkCnt_q <= '0;
            cursor_q   <= ~cursor_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + BW'(1);
        end
    end

    // Request is decoded from state so an asynchronous reset drops it immediately.
    always_comb begin
        rd_req  = (state_q == S_REQ) || (state_q == S_WAIT);
        rd_addr = 8'h00;
        if (rd_req) begin
            case (slot_q)
                4'd0:    rd_addr = 8'h24;
                4'd1:    rd_addr = 8'h25;
                4'd2:    rd_addr = 8'h26;
                4'd3:    rd_addr = 8'h23;
                4'd4:    rd_addr = 8'h22;
                4'd5:    rd_addr = 8'h21;
                4'd6:    rd_addr = 8'h43;
                4'd7:    rd_addr = 8'h42;
                4'd8:    rd_addr = 8'h41;
                default: rd_addr = 8'h00;
            endcase
        end
    end

    assign decenas     = dec_q;
    assign unidades    = uni_q;
    assign direccion   = dir_q;
    assign dato_valido = valid_q;
    assign rd_error    = err_q;
    assign cursor      = cursor_q;
endmodule

// File: tb/tb_rtc_bcd_scanner.sv
// Bench for rtc_bcd_scanner: acts as the RTC responder with random data and ack delays and
// predicts addresses, digits, strobes, error flag, timing and cursor from plain arithmetic.
module tb_rtc_bcd_scanner;
    localparam int TIMEOUT_CYC = 16;
    localparam int GAP_CYC     = 4;
    localparam int REFRESH_CYC = 20;
    localparam int BLINK_CYC   = 8;

    logic       reloj = 1'b0;
    logic       reset;
    logic       pausa;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [3:0] decenas;
    logic [3:0] unidades;
    logic [3:0] direccion;
    logic       dato_valido;
    logic       rd_error;
    logic       cursor;

    int checks   = 0;
    int errors   = 0;
    int sinceRst = 0;
    int expDec   = 0;
    int expUni   = 0;
    int expDir   = 0;
    int expErr   = 0;
    logic [7:0] addrMap [9] = '{8'h24, 8'h25, 8'h26, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};

    rtc_bcd_scanner #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC(GAP_CYC),
        .REFRESH_CYC(REFRESH_CYC),
        .BLINK_CYC(BLINK_CYC)
    ) dut (
        .reloj(reloj),
        .reset(reset),
        .pausa(pausa),
        .rd_ack(rd_ack),
        .rd_data(rd_data),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .decenas(decenas),
        .unidades(unidades),
        .direccion(direccion),
        .dato_valido(dato_valido),
        .rd_error(rd_error),
        .cursor(cursor)
    );

    // Free-running clock.
    always #5 reloj = ~reloj;

    // Rising edges seen since reset was last released; the cursor phase follows from it.
    always @(posedge reloj or negedge reset) begin
        if (!reset) sinceRst <= 0;
        else        sinceRst <= sinceRst + 1;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkCursor();
        checkOutput("cursor", int'(cursor), (sinceRst / BLINK_CYC) % 2);
    endtask

    // Called on the first cycle rd_req is seen high; serves one read and checks its result.
    task automatic applyStimulus(input int slot, input int delay, input logic [7:0] data,
                                 input bit noAck);
        int hi;
        int tens;
        int units;
        checkOutput("req_addr", int'(rd_addr), int'(addrMap[slot]));
        if (noAck) begin
            hi = 1;
            while (rd_req === 1'b1 && hi <= TIMEOUT_CYC + 4) begin
                tick();
                if (rd_req === 1'b1) hi++;
            end
            expErr = 1;
            checkOutput("timeout_len", hi, TIMEOUT_CYC + 1);
            checkOutput("timeout_err", int'(rd_error), expErr);
            checkOutput("timeout_nostrobe", int'(dato_valido), 0);
            checkOutput("timeout_hold_dir", int'(direccion), expDir);
            checkOutput("timeout_hold_dec", int'(decenas), expDec);
        end else begin
            repeat (delay) tick();
            checkOutput("wait_req", int'(rd_req), 1);
            rd_ack  = 1'b1;
            rd_data = data;
            tick();
            rd_ack  = 1'b0;
            rd_data = 8'($urandom);
            checkOutput("ack_drop", int'(rd_req), 0);
            checkOutput("early_strobe", int'(dato_valido), 0);
            tick();
            tens  = int'(data) / 16;
            units = int'(data) % 16;
            if (tens > 9 || units > 9) expErr = 1;
            expDec = (tens > 9) ? 0 : tens;
            expUni = (units > 9) ? 0 : units;
            expDir = slot;
            checkOutput("strobe", int'(dato_valido), 1);
            checkOutput("decenas", int'(decenas), expDec);
            checkOutput("unidades", int'(unidades), expUni);
            checkOutput("direccion", int'(direccion), expDir);
            checkOutput("rd_error", int'(rd_error), expErr);
        end
    endtask

    task automatic expectNextReq(input int ticks, input string tag);
        bit lowOk;
        lowOk = 1'b1;
        for (int i = 1; i < ticks; i++) begin
            tick();
            if (rd_req !== 1'b0 || dato_valido !== 1'b0) lowOk = 1'b0;
        end
        tick();
        checkOutput({tag, "_quiet"}, int'(lowOk), 1);
        checkOutput({tag, "_req"}, int'(rd_req), 1);
    endtask

    initial begin
        bit holdOk;
        logic [7:0] d;
        reset   = 1'b1;
        pausa   = 1'b1;
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        #1 reset = 1'b0;
        repeat (3) @(posedge reloj);
        #1;
        checkOutput("rst_req", int'(rd_req), 0);
        checkOutput("rst_addr", int'(rd_addr), 0);
        checkOutput("rst_dec", int'(decenas), 0);
        checkOutput("rst_uni", int'(unidades), 0);
        checkOutput("rst_dir", int'(direccion), 0);
        checkOutput("rst_valid", int'(dato_valido), 0);
        checkOutput("rst_err", int'(rd_error), 0);
        checkOutput("rst_cursor", int'(cursor), 0);
        reset = 1'b1;

        repeat (5) tick();
        checkOutput("idle_hold", int'(rd_req), 0);
        checkCursor();
        pausa = 1'b0;
        tick();
        checkOutput("resume_req", int'(rd_req), 1);

        $display("[TB] sweep A: clean data, slot 0 = 0x31");
        for (int s = 0; s < 9; s++) begin
            d = (s == 0) ? 8'h31 : 8'(s * 17);
            applyStimulus(s, (s == 0) ? 3 : int'($urandom_range(1, 6)), d, 1'b0);
            checkCursor();
            expectNextReq((s == 8) ? GAP_CYC + REFRESH_CYC : GAP_CYC, "sweepA");
        end

        $display("[TB] sweep B: random data, 0xA7 on slot 1, timeout on slot 4");
        for (int s = 0; s < 9; s++) begin
            d = (s == 1) ? 8'hA7 : 8'($urandom);
            applyStimulus(s, int'($urandom_range(1, 6)), d, s == 4);
            checkCursor();
            expectNextReq((s == 8) ? GAP_CYC + REFRESH_CYC : GAP_CYC, "sweepB");
        end

        $display("[TB] pause during a read and during the gap");
        for (int s = 0; s < 2; s++) begin
            applyStimulus(s, int'($urandom_range(1, 6)), 8'($urandom), 1'b0);
            expectNextReq(GAP_CYC, "sweepC");
        end
        tick();
        pausa = 1'b1;
        applyStimulus(2, 2, 8'h59, 1'b0);
        holdOk = 1'b1;
        repeat (6) begin
            tick();
            if (rd_req !== 1'b0) holdOk = 1'b0;
        end
        checkOutput("pause_read_idle", int'(holdOk), 1);
        pausa = 1'b0;
        tick();
        checkOutput("pause_read_resume", int'(rd_req), 1);
        applyStimulus(0, int'($urandom_range(1, 6)), 8'($urandom), 1'b0);
        pausa  = 1'b1;
        holdOk = 1'b1;
        repeat (8) begin
            tick();
            if (rd_req !== 1'b0) holdOk = 1'b0;
        end
        checkOutput("pause_gap_idle", int'(holdOk), 1);
        pausa = 1'b0;
        tick();
        checkOutput("pause_gap_resume", int'(rd_req), 1);
        applyStimulus(0, 1, 8'h42, 1'b0);
        expectNextReq(GAP_CYC, "preReset");

        $display("[TB] reset in the middle of a request");
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_req", int'(rd_req), 0);
        checkOutput("midrst_addr", int'(rd_addr), 0);
        checkOutput("midrst_dec", int'(decenas), 0);
        checkOutput("midrst_uni", int'(unidades), 0);
        checkOutput("midrst_dir", int'(direccion), 0);
        checkOutput("midrst_err", int'(rd_error), 0);
        checkOutput("midrst_cursor", int'(cursor), 0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkCursor();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
